spi_master_fifo: RTL and testbench

- Parametrised SPI master that generalises the fixed 8-bit, mode-0-only display SPI driver.
- Adds programmable data width, all four CPOL/CPHA modes, a run-time clock divider, a TX FIFO, and full-duplex MISO capture.
- Memory-mapped by the CPU-side glue (register decode outside this block) and drives PMOD peripherals (OLED, ADC/DAC) from the 125 MHz domain.
- Panel power (pmoden/vccen) stays in top-level glue and is not part of this block.

---
 rtl/spi_master_fifo.sv | 253 +++++++++++++++++++++++++
 tb/tb_spi_master_fifo.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_fifo.sv
// SPI master with a TX FIFO, programmable word width, all four CPOL/CPHA modes and full-duplex capture.
// cs_n is low for (2*DATA_W+2)*HALF cycles per word; pushes into a full FIFO are dropped and flagged sticky.
module spi_master_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 8,
  parameter int DIV_RESET  = 50
) (
  input  logic                          clk_125mhz,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          wr_dc,
  input  logic                          cfg_we,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic                          cfg_cpol,
  input  logic                          cfg_cpha,
  input  logic                          miso,
  output logic                          sck,
  output logic                          mosi,
  output logic                          cs_n,
  output logic                          dc,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  output logic                          busy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = $clog2(2 * DATA_W) + 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [EW-1:0]       edge_q, edge_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic                sck_q, sck_d;
  logic                mosi_q, mosi_d;
  logic                cs_n_q, cs_n_d;
  logic                dc_q, dc_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic [DIV_W-1:0]    sh_div_q, sh_div_d;
  logic                sh_cpol_q, sh_cpol_d;
  logic                sh_cpha_q, sh_cpha_d;
  logic                overflow_q, overflow_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                miso_meta_q, miso_sync_q;

  logic [DATA_W:0]     mem [FIFO_DEPTH];
  logic [DATA_W:0]     rd_entry;
  logic                full_w, push, pop, cnt_done, sample_edge;
  logic [DIV_W-1:0]    half;

  assign full_w   = (count_q == CW'(FIFO_DEPTH));
  assign push     = wr_en && !full_w;
  assign pop      = (state_q == ST_IDLE) && (count_q != '0);
  assign rd_entry = mem[rd_ptr_q];
  assign half     = (sh_div_q == '0) ? DIV_W'(1) : sh_div_q;
  assign cnt_done = (cnt_q == half - DIV_W'(1));

  always_ff @(posedge clk_125mhz) begin
    if (push) mem[wr_ptr_q] <= {wr_dc, wr_data};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_d      = edge_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    dc_d        = dc_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    div_d       = div_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    sh_div_d    = sh_div_q;
    sh_cpol_d   = sh_cpol_q;
    sh_cpha_d   = sh_cpha_q;
    overflow_d  = overflow_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    sample_edge = 1'b0;

    if (cfg_we) begin
      div_d      = cfg_div;
      cpol_d     = cfg_cpol;
      cpha_d     = cfg_cpha;
      overflow_d = 1'b0;
    end
    if (wr_en && full_w) overflow_d = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        sck_d = sh_cpol_q;
        if (pop) begin
          sh_div_d  = div_q;
          sh_cpol_d = cpol_q;
          sh_cpha_d = cpha_q;
          sck_d     = cpol_q;
          dc_d      = rd_entry[DATA_W];
          cs_n_d    = 1'b0;
          cnt_d     = '0;
          edge_d    = '0;
          rx_sr_d   = '0;
          // CPHA=0 presents the MSB before the first edge; CPHA=1 drives it on the leading edge.
          if (!cpha_q) begin
            mosi_d  = rd_entry[DATA_W-1];
            tx_sr_d = rd_entry[DATA_W-1:0] << 1;
          end else begin
            tx_sr_d = rd_entry[DATA_W-1:0];
          end
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      ST_SHIFT: begin
        if (cnt_done) begin
          cnt_d       = '0;
          sck_d       = ~sck_q;
          edge_d      = edge_q + EW'(1);
          sample_edge = (edge_q[0] == sh_cpha_q);
          if (sample_edge) begin
            rx_sr_d = {rx_sr_q[DATA_W-2:0], miso_sync_q};
          end else if (!(edge_q == LAST_EDGE && !sh_cpha_q)) begin
            mosi_d  = tx_sr_q[DATA_W-1];
            tx_sr_d = tx_sr_q << 1;
          end
          if (edge_q == LAST_EDGE) state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          cnt_d      = '0;
          cs_n_d     = 1'b1;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          state_d    = ST_GAP;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      edge_q      <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      dc_q        <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      div_q       <= DIV_W'(DIV_RESET);
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      sh_div_q    <= DIV_W'(DIV_RESET);
      sh_cpol_q   <= 1'b0;
      sh_cpha_q   <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edge_q      <= edge_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      dc_q        <= dc_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      div_q       <= div_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      sh_div_q    <= sh_div_d;
      sh_cpol_q   <= sh_cpol_d;
      sh_cpha_q   <= sh_cpha_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      miso_meta_q <= miso;
      miso_sync_q <= miso_meta_q;
    end
  end

  assign sck        = sck_q;
  assign mosi       = mosi_q;
  assign cs_n       = cs_n_q;
  assign dc         = dc_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign fifo_full  = full_w;
  assign fifo_empty = (count_q == '0);
  assign busy       = (state_q != ST_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed and randomized bench for spi_master_fifo; a bus monitor rebuilds each frame and compares it to the expected word and timing.
module tb_spi_master_fifo;

  logic       clk_125mhz = 1'b0;
  logic       reset;
  logic       wr_en, wr_dc, cfg_we, cfg_cpol, cfg_cpha;
  logic [7:0] wr_data, cfg_div;
  logic       miso, miso_const, loop_en;
  logic       sck, mosi, cs_n, dc, rx_valid, busy, fifo_full, fifo_empty, overflow;
  logic [7:0] rx_data;
  logic [3:0] fifo_count;

  assign miso = loop_en ? mosi : miso_const;

  always #4 clk_125mhz = ~clk_125mhz;

  spi_master_fifo #(.DATA_W(8), .FIFO_DEPTH(8), .DIV_W(8), .DIV_RESET(50)) dut (
    .clk_125mhz(clk_125mhz), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data), .wr_dc(wr_dc),
    .cfg_we(cfg_we), .cfg_div(cfg_div), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .miso(miso), .sck(sck), .mosi(mosi), .cs_n(cs_n), .dc(dc),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    int          cs_low;
    int          nedges;
    int          hmin;
    int          hmax;
    logic        dc;
    int          gap;
  } frame_t;

  frame_t     fq[$];
  logic [7:0] rxq[$];
  frame_t     cur, last_fr;
  int         n_chk = 0, n_pass = 0, n_fail = 0;
  int         cyc = 0, last_tog = 0, iv = 0, gap_cnt = 0, tail_cnt = 0, busy_tail = -1, rx_pulses = 0;
  logic       in_frame = 1'b0, prev_cs = 1'b1, prev_sck = 1'b0, tail_active = 1'b0;
  logic       m_cpol = 1'b0, m_cpha = 1'b0;

  // Bus monitor: sees only pins, reconstructs the word at the sampling edge of the active mode.
  always @(negedge clk_125mhz) begin
    cyc++;
    if (reset) begin
      in_frame    = 1'b0;
      prev_cs     = 1'b1;
      tail_active = 1'b0;
      gap_cnt     = 0;
    end else begin
      if (rx_valid) begin
        rxq.push_back(rx_data);
        rx_pulses++;
      end
      if (!cs_n) begin
        if (prev_cs) begin
          cur.bits = '0; cur.nbits = 0; cur.cs_low = 1; cur.nedges = 0;
          cur.hmin = 1000000; cur.hmax = 0; cur.dc = dc; cur.gap = gap_cnt;
          in_frame = 1'b1; prev_sck = sck; last_tog = cyc;
        end else if (in_frame) begin
          cur.cs_low++;
          if (sck != prev_sck) begin
            if (cur.nedges > 0) begin
              iv = cyc - last_tog;
              if (iv < cur.hmin) cur.hmin = iv;
              if (iv > cur.hmax) cur.hmax = iv;
            end
            last_tog = cyc;
            cur.nedges++;
            prev_sck = sck;
            if ((sck != m_cpol) != m_cpha) begin
              cur.bits = {cur.bits[30:0], mosi};
              cur.nbits++;
            end
          end
        end
      end else begin
        if (!prev_cs) begin
          if (in_frame) fq.push_back(cur);
          in_frame    = 1'b0;
          gap_cnt     = 1;
          tail_active = 1'b1;
          tail_cnt    = 0;
        end else begin
          gap_cnt++;
        end
      end
      if (tail_active) begin
        if (busy) tail_cnt++;
        else begin
          busy_tail   = tail_cnt;
          tail_active = 1'b0;
        end
      end
      prev_cs = cs_n;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_125mhz);
    #1;
  endtask

  task automatic push(input logic [7:0] w, input logic d);
    wr_en = 1'b1; wr_data = w; wr_dc = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] dv, input logic cp, input logic ch);
    cfg_we = 1'b1; cfg_div = dv; cfg_cpol = cp; cfg_cpha = ch;
    tick(1);
    cfg_we = 1'b0;
    m_cpol = cp; m_cpha = ch;
  endtask

  // Expected frame from first principles: MSB-first bits, (2*W+2)*HALF cs_n-low cycles, HALF per half-period.
  task automatic check_frame(input string tag, input logic [7:0] word, input logic dcv,
                             input int h, input logic [7:0] rxv);
    for (int i = 0; i < 6000; i++) begin
      if (fq.size() != 0) break;
      tick(1);
    end
    if (fq.size() == 0) begin
      chk({tag, ".timeout"}, 64'(fq.size()), 64'd1);
      return;
    end
    last_fr = fq.pop_front();
    chk({tag, ".bits"},   64'(last_fr.bits),   64'(word));
    chk({tag, ".nbits"},  64'(last_fr.nbits),  64'd8);
    chk({tag, ".cs_low"}, 64'(last_fr.cs_low), 64'((2 * 8 + 2) * h));
    chk({tag, ".nedges"}, 64'(last_fr.nedges), 64'd16);
    chk({tag, ".hmin"},   64'(last_fr.hmin),   64'(h));
    chk({tag, ".hmax"},   64'(last_fr.hmax),   64'(h));
    chk({tag, ".dc"},     64'(last_fr.dc),     64'(dcv));
    if (rxq.size() == 0) chk({tag, ".rx_missing"}, 64'(rxq.size()), 64'd1);
    else chk({tag, ".rx"}, 64'(rxq.pop_front()), 64'(rxv));
  endtask

  initial begin
    logic [7:0] words [3];
    int         pulses_before;
    int         rdiv;
    logic       rcp, rch, rdc;
    logic [7:0] rw;

    reset = 1'b1; wr_en = 1'b0; wr_data = '0; wr_dc = 1'b0;
    cfg_we = 1'b0; cfg_div = '0; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
    miso_const = 1'b1; loop_en = 1'b0;
    tick(3);
    chk("rst.sck", 64'(sck), 64'd0);
    chk("rst.cs_n", 64'(cs_n), 64'd1);
    reset = 1'b0;
    tick(2);
    chk("rst.mosi", 64'(mosi), 64'd0);
    chk("rst.dc", 64'(dc), 64'd0);
    chk("rst.rx_data", 64'(rx_data), 64'd0);
    chk("rst.rx_valid", 64'(rx_valid), 64'd0);
    chk("rst.overflow", 64'(overflow), 64'd0);
    chk("rst.empty", 64'(fifo_empty), 64'd1);
    chk("rst.count", 64'(fifo_count), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);

    // Mode 0, div 2, miso held high.
    cfg(8'd2, 1'b0, 1'b0);
    push(8'hA5, 1'b1);
    check_frame("m0", 8'hA5, 1'b1, 2, 8'hFF);
    tick(10);
    chk("m0.pulses", 64'(rx_pulses), 64'd1);

    // Modes 1..3 with loopback.
    loop_en = 1'b1;
    for (int m = 1; m < 4; m++) begin
      cfg(8'd3, 1'(m >> 1), 1'(m & 1));
      push(8'h3C, 1'b0);
      check_frame($sformatf("mode%0d", m), 8'h3C, 1'b0, 3, 8'h3C);
      tick(8);
      chk($sformatf("mode%0d.sck_idle", m), 64'(sck), 64'(m >> 1));
    end
    loop_en = 1'b0;

    // Back-to-back at div 1.
    cfg(8'd1, 1'b0, 1'b0);
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    for (int i = 0; i < 3; i++) push(words[i], 1'(i & 1));
    for (int i = 0; i < 3; i++) begin
      check_frame($sformatf("b2b%0d", i), words[i], 1'(i & 1), 1, 8'hFF);
      if (i > 0) chk($sformatf("b2b%0d.gap", i), 64'(last_fr.gap), 64'd2);
    end
    tick(5);
    chk("b2b.busy_tail", 64'(busy_tail), 64'd1);
    chk("b2b.busy_end", 64'(busy), 64'd0);

    // Divider change mid-frame applies to the next word only; 0 acts as 1.
    cfg(8'd2, 1'b0, 1'b0);
    push(8'h5A, 1'b0);
    push(8'hC3, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      if (cs_n == 1'b0 && cur.nedges >= 2 && cur.nedges < 10) break;
      tick(1);
    end
    cfg(8'd5, 1'b0, 1'b0);
    check_frame("div_a", 8'h5A, 1'b0, 2, 8'hFF);
    check_frame("div_b", 8'hC3, 1'b1, 5, 8'hFF);
    cfg(8'd0, 1'b0, 1'b0);
    push(8'h96, 1'b0);
    check_frame("div0", 8'h96, 1'b0, 1, 8'hFF);
    cfg(8'd1, 1'b0, 1'b0);
    push(8'h96, 1'b0);
    check_frame("div1", 8'h96, 1'b0, 1, 8'hFF);
    tick(5);

    // Fill the FIFO behind a slow frame, then overflow.
    cfg(8'd200, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) push(8'(i), 1'b0);
    chk("ovf.cs_low", 64'(cs_n), 64'd0);
    chk("ovf.count8", 64'(fifo_count), 64'd8);
    chk("ovf.full", 64'(fifo_full), 64'd1);
    chk("ovf.clear", 64'(overflow), 64'd0);
    push(8'hEE, 1'b0);
    chk("ovf.set", 64'(overflow), 64'd1);
    chk("ovf.count_kept", 64'(fifo_count), 64'd8);
    cfg_we = 1'b1; wr_en = 1'b1;
    tick(1);
    cfg_we = 1'b0; wr_en = 1'b0;
    chk("ovf.set_wins", 64'(overflow), 64'd1);
    cfg(8'd200, 1'b0, 1'b0);
    chk("ovf.cfg_clears", 64'(overflow), 64'd0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    m_cpol = 1'b0; m_cpha = 1'b0;
    tick(2);
    chk("ovf.flushed", 64'(fifo_count), 64'd0);

    // Reset in the middle of word 2 of 4.
    cfg(8'd3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i), 1'b0);
    check_frame("rstmid0", 8'h40, 1'b0, 3, 8'hFF);
    for (int i = 0; i < 2000; i++) begin
      if (cs_n == 1'b0 && cur.nedges >= 4 && cur.nedges < 10) break;
      tick(1);
    end
    chk("rstmid.in_shift", 64'(cs_n), 64'd0);
    pulses_before = rx_pulses;
    reset = 1'b1;
    #1;
    chk("rstmid.cs_n", 64'(cs_n), 64'd1);
    chk("rstmid.sck", 64'(sck), 64'd0);
    chk("rstmid.empty", 64'(fifo_empty), 64'd1);
    chk("rstmid.count", 64'(fifo_count), 64'd0);
    tick(4);
    reset = 1'b0;
    m_cpol = 1'b0; m_cpha = 1'b0;
    tick(300);
    chk("rstmid.busy", 64'(busy), 64'd0);
    chk("rstmid.cs_idle", 64'(cs_n), 64'd1);
    chk("rstmid.no_pulse", 64'(rx_pulses), 64'(pulses_before));
    chk("rstmid.no_frame", 64'(fq.size()), 64'd0);

    // Randomized modes, dividers and words with loopback.
    loop_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rdiv = int'($urandom_range(3, 6));
      rcp  = 1'($urandom_range(0, 1));
      rch  = 1'($urandom_range(0, 1));
      rdc  = 1'($urandom_range(0, 1));
      rw   = 8'($urandom);
      cfg(8'(rdiv), rcp, rch);
      push(rw, rdc);
      check_frame($sformatf("rnd%0d", k), rw, rdc, rdiv, rw);
      chk($sformatf("rnd%0d.sck_end", k), 64'(sck), 64'(rcp));
      tick(2 * rdiv + 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
